// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART transmitter and the future receiver
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam int OVERSAMPLE    = 16;
    localparam int DATA_BITS_DEF = 8;
    localparam int SB_TICK_DEF   = 16;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: serialises din as start bit, LSB-first data bits and stop bit, timed by 16x s_tick enables
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous active-low reset
//   s_tick       one-cycle 16x-baud enable
//   tx_start     request to send din, honoured only in IDLE
//   din          byte to send, captured when tx_start is accepted
//   tx           registered serial line, idle high
//   tx_busy      high whenever not in IDLE
//   tx_done_tick one-cycle pulse after the stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int SB_TICK   = SB_TICK_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);
    // tick counter widens beyond 4 bits only when the stop bit needs more than 16 ticks
    localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    uart_state_e          state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 tx_q;
    logic                 done_q;
    assign shift_d      = shift_q >> 1;
    assign tx           = tx_q;
    assign tx_busy      = state_q != IDLE;
    assign tx_done_tick = done_q;
    // tx_q is loaded with the line level of the state being entered so it stays aligned with state_q
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (tx_start) begin
                    shift_q <= din;
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                DATA: if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_q  <= '0;
                        shift_q <= shift_d;
                        if (bit_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            tx_q  <= shift_d[0];
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                STOP: if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench; lane 0 uses default parameters, lane 1 a two-stop-bit transmitter
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic [1:0] start = 2'b00;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [1:0] tx_w, busy_w, done_w;
    int errors = 0;
    int checks = 0;
    int mode = 0;
    int scnt = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    uart_tx dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[0]), .din(din0),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
    );
    uart_tx #(.SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[1]), .din(din1),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
    );

    // mode 0: tick every cycle, mode 1: one tick in 16 cycles, mode 2: random ticks
    initial forever begin
        @(posedge clk);
        #2;
        scnt++;
        s_tick = (mode == 0) ? 1'b1 : (mode == 1) ? (scnt % 16 == 0) : ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: a frame is 16 low ticks, 16 ticks per data bit LSB first, then sb high ticks
    task automatic mon(input int l);
        bit         smp[$];
        int         bc, n, sb, bad;
        logic       pd, pds, eb;
        logic [7:0] e, got;
        bc = 0; pd = 0; pds = 0;
        sb = (l == 0) ? 16 : 32;
        n = 16 + 16 * 8 + sb;
        forever begin
            @(negedge clk);
            if (!reset) begin
                smp.delete(); bc = 0; pd = 0; pds = 0;
                continue;
            end
            if (pds) chk("b2b_restart", int'(busy_w[l]), 1);
            if (done_w[l]) begin
                chk("done_busy_low", int'(busy_w[l]), 0);
                chk("done_width", int'(pd), 0);
                if ((l == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done lane %0d: got done expected none", l);
                end else begin
                    e = (l == 0) ? q0.pop_front() : q1.pop_front();
                    bad = (smp.size() != n) ? 1 : 0;
                    got = 8'h00;
                    for (int i = 0; i < n; i++) begin
                        eb = (i < 16) ? 1'b0 : (i < 144) ? e[(i - 16) / 16] : 1'b1;
                        if (i < smp.size() && smp[i] != eb) bad = 1;
                    end
                    for (int k = 0; k < 8; k++)
                        if (16 + 16 * k + 8 < smp.size()) got[k] = smp[16 + 16 * k + 8];
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame lane %0d: got data %h ticks %0d expected data %h ticks %0d", l, got, smp.size(), e, n);
                    end
                    if (mode == 0) chk("busy_cycles", bc, n);
                    if (mode == 1) chk("busy_cycles_1in16", int'(bc >= 2545 && bc <= 2575), 1);
                end
                smp.delete(); bc = 0;
            end else if (!busy_w[l]) begin
                chk("idle_tx_high", int'(tx_w[l]), 1);
            end
            if (busy_w[l]) begin
                bc++;
                if (s_tick) smp.push_back(tx_w[l]);
            end
            pds = done_w[l] && start[l];
            pd = done_w[l];
        end
    endtask

    task automatic send(input int l, input logic [7:0] d);
        @(posedge clk);
        #2;
        if (l == 0) begin din0 = d; q0.push_back(d); end
        else begin din1 = d; q1.push_back(d); end
        start[l] = 1'b1;
        @(posedge clk);
        #2;
        start[l] = 1'b0;
    endtask

    task automatic wait_done(input int l);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[l] && n < 20000);
        if (!done_w[l]) begin
            checks++; errors++;
            $display("FAIL timeout lane %0d: got no done expected done", l);
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", int'(tx_w[0]), 1);
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_done", int'(done_w[0]), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        send(0, 8'hA5);
        wait_done(0);
        mode = 1;
        send(0, 8'h00);
        wait_done(0);
        mode = 0;
        send(0, 8'h3C);
        repeat (50) @(posedge clk);
        #2;
        din0 = 8'hFF;
        start[0] = 1'b1;
        @(posedge clk);
        #2;
        start[0] = 1'b0;
        wait_done(0);
        send(0, 8'h96);
        repeat (70) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        q0.delete();
        din0 = 8'h55;
        q0.push_back(8'h55);
        start[0] = 1'b1;
        @(negedge clk);
        chk("abort_tx", int'(tx_w[0]), 1);
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_done", int'(done_w[0]), 0);
        @(posedge clk);
        #2;
        start[0] = 1'b0;
        wait_done(0);
        for (int f = 0; f < 6; f++) begin
            mode = (f < 4) ? 2 : 0;
            send(0, 8'($urandom));
            repeat (20) begin
                @(posedge clk);
                #2;
                din0 = 8'($urandom);
                start[0] = 1'($urandom);
            end
            start[0] = 1'b0;
            wait_done(0);
        end
        mode = 0;
        @(posedge clk);
        #2;
        din1 = 8'($urandom);
        repeat (3) q1.push_back(din1);
        start[1] = 1'b1;
        wait_done(1);
        wait_done(1);
        repeat (5) @(posedge clk);
        #2;
        start[1] = 1'b0;
        wait_done(1);
        repeat (40) @(posedge clk);
        chk("lane0_pending", q0.size(), 0);
        chk("lane1_pending", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_tick  input  1  one-cycle enable pulse at 16x baud from the tx sample ticker; used only as an enable, never as a clock.
REQ-006 tx_start  input  1  request to send din; sampled only in IDLE.
REQ-007 din  input  DATA_BITS  byte to transmit; captured in the cycle tx_start is accepted.
REQ-008 tx  output  1  serial line; registered; idle high.
REQ-009 tx_busy  output  1  high whenever state is not IDLE.
REQ-010 tx_done_tick  output  1  one-cycle pulse at frame completion.

Function
REQ-011 FSM states: IDLE, START, DATA, STOP; state, tick counter (4 bits), bit counter (clog2 DATA_BITS bits) and shift register are all registered.
REQ-012 IDLE: tx=1; when tx_start=1, latch din into the shift register, clear both counters, go to START; tx=0 from the next cycle.
REQ-013 START: tx=0; on each s_tick increment the tick counter; on the s_tick where it equals 15, clear it and go to DATA.
REQ-014 DATA: tx=shift_reg[0] (LSB first); on the s_tick where the tick counter equals 15, clear it and shift right by one; if the bit counter equals DATA_BITS-1, go to STOP, else increment it.
REQ-015 STOP: tx=1; on the s_tick where the tick counter equals SB_TICK-1, go to IDLE and pulse tx_done_tick high for exactly that one following cycle.
REQ-016 Frame length = 16 + 16*DATA_BITS + SB_TICK s_tick pulses (160 with defaults).
REQ-017 Cycles without s_tick leave the counters, state and tx unchanged.
REQ-018 tx_start while busy: ignored; no queueing; din changes while busy have no effect.
REQ-019 tx_start and s_tick in the same IDLE cycle: start accepted; that tick is not counted.
REQ-020 tx_start held high across the cycle tx_done_tick is asserted: the next frame starts from IDLE in the following cycle, so frames run back to back with no extra idle bit.
REQ-021 tx_busy is low in the same cycle tx_done_tick is high.

Reset
REQ-022 reset=0 at a rising clk edge: state=IDLE, tick counter=0, bit counter=0, shift register=0, tx=1, tx_busy=0, tx_done_tick=0, effective on that edge.
REQ-023 Reset mid-frame aborts the frame: tx returns to 1 after that edge, no tx_done_tick is produced, and a new tx_start is accepted in the first cycle after reset is released.

Structure
REQ-024 Package uart_pkg holds the state encoding enum, OVERSAMPLE=16, and the default DATA_BITS/SB_TICK constants, shared with the future uart_rx.
REQ-025 Single flat module with no sub-modules; s_tick comes from the existing tx sample ticker instance at top level.

Verification
REQ-026 s_tick held high every cycle, din=8'hA5, one-cycle tx_start -> tx low for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16; tx_done_tick pulses once; tx_busy high for 160 cycles.
REQ-027 s_tick pulsing 1-in-16 cycles, din=8'h00 -> 9 low bit periods of 256 cycles each, then a 256-cycle stop bit; frame totals 2560 cycles +/- 15.
REQ-028 Second tx_start with din=8'hFF pulsed mid-frame of an 8'h3C transmission -> only 8'h3C appears on tx; one tx_done_tick.
REQ-029 reset=0 for one cycle during DATA bit 3 -> tx=1 and tx_busy=0 on the next edge, no tx_done_tick; a following 8'h55 frame is transmitted intact.
REQ-030 tx_start held high continuously with SB_TICK=32 -> back-to-back frames, each with a 32-tick stop bit, START directly after STOP, and one tx_done_tick per frame.
